column_sequencer: RTL and testbench

//  Game-level controller for NUM_COLS falling-letter columns. Owns the fall timebase, releases

---
 rtl/column_sequencer_if.sv | 39 +++
 rtl/column_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_column_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/column_sequencer_if.sv
// column_sequencer_if
//   Groups the column sequencer's game-side signals: the start and keyboard
//   inputs, the per-column status coming back from the column array, and the
//   control/score outputs driven towards the columns and the display.
//   Ports (as signals):
//     start, key_valid, key_code[7:0]           game and keyboard inputs
//     col_letter[8N-1:0], col_ypos[5N-1:0],
//     col_landed[N-1:0]                          column status inputs
//     col_enable, col_tick, col_clear [N-1:0]    column control outputs
//     score[9:0], lives[1:0], state[1:0],
//     game_over                                  game status outputs
//   Modports: slave = sequencer side, master = environment side.
interface column_sequencer_if #(
    parameter int NUM_COLS = 4
);
    logic                    start;
    logic                    key_valid;
    logic [7:0]              key_code;
    logic [8*NUM_COLS-1:0]   col_letter;
    logic [5*NUM_COLS-1:0]   col_ypos;
    logic [NUM_COLS-1:0]     col_landed;
    logic [NUM_COLS-1:0]     col_enable;
    logic [NUM_COLS-1:0]     col_tick;
    logic [NUM_COLS-1:0]     col_clear;
    logic [9:0]              score;
    logic [1:0]              lives;
    logic [1:0]              state;
    logic                    game_over;

    modport slave (
        input  start, key_valid, key_code, col_letter, col_ypos, col_landed,
        output col_enable, col_tick, col_clear, score, lives, state, game_over
    );

    modport master (
        output start, key_valid, key_code, col_letter, col_ypos, col_landed,
        input  col_enable, col_tick, col_clear, score, lives, state, game_over
    );
endinterface

// File: rtl/column_sequencer.sv
// column_sequencer
//   Game-level controller for NUM_COLS falling-letter columns. Owns the fall
//   timebase and its speed-up, releases columns one at a time, routes each key
//   strobe to the lowest (largest ypos) matching column, detects misses on the
//   rising edge of col_landed, and keeps score and lives through the
//   IDLE / PLAYING / GAME_OVER state machine.
//   Ports:
//     clock         system clock, rising edge
//     reset_signal  asynchronous, active-high reset
//     bus           column_sequencer_if.slave (start, key strobe, column
//                   status in; col_enable/col_tick/col_clear, score, lives,
//                   state, game_over out; all outputs registered)
module column_sequencer #(
    parameter int NUM_COLS      = 4,
    parameter int TICK_START    = 50000000,
    parameter int TICK_MIN      = 12500000,
    parameter int TICK_STEP     = 2500000,
    parameter int SPEEDUP_EVERY = 8,
    parameter int MAX_LIVES     = 3
) (
    input  logic                clock,
    input  logic                reset_signal,
    column_sequencer_if.slave   bus
);

    localparam int HIT_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

    localparam logic [25:0]         PERIOD_START = 26'(TICK_START);
    localparam logic [25:0]         PERIOD_MIN   = 26'(TICK_MIN);
    localparam logic [25:0]         PERIOD_STEP  = 26'(TICK_STEP);
    // Smallest period that can still take a full step without dropping below the floor.
    localparam logic [25:0]         PERIOD_KNEE  = 26'(TICK_MIN + TICK_STEP);
    localparam logic [HIT_W-1:0]    HIT_LAST     = HIT_W'(SPEEDUP_EVERY - 1);
    localparam logic [1:0]          LIVES_INIT   = 2'(MAX_LIVES);
    localparam logic [NUM_COLS-1:0] COL_ONE      = NUM_COLS'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } state_t;

    state_t              state_r,     state_s;
    logic [9:0]          score_r,     score_s;
    logic [1:0]          lives_r,     lives_s;
    logic [25:0]         period_r,    period_s;
    logic [25:0]         tick_cnt_r,  tick_cnt_s;
    logic [HIT_W-1:0]    hit_cnt_r,   hit_cnt_s;
    logic [NUM_COLS-1:0] enable_r,    enable_s;
    logic [NUM_COLS-1:0] col_tick_r,  col_tick_s;
    logic [NUM_COLS-1:0] col_clear_r, col_clear_s;
    logic [NUM_COLS-1:0] landed_q_r;
    logic                game_over_r;

    logic [NUM_COLS-1:0] miss_s;
    logic [3:0]          miss_cnt_s;
    logic [NUM_COLS-1:0] cand_s;
    logic [NUM_COLS-1:0] win_s;
    logic                win_found_s;
    logic [4:0]          best_y_s;

    // Miss detection and key arbitration: one winner, deepest column first, lowest index on ties.
    always_comb begin
        miss_s      = bus.col_landed & ~landed_q_r & enable_r;
        miss_cnt_s  = 4'd0;
        cand_s      = '0;
        win_s       = '0;
        win_found_s = 1'b0;
        best_y_s    = 5'd0;
        for (int i = 0; i < NUM_COLS; i++) begin
            miss_cnt_s = miss_cnt_s + {3'b000, miss_s[i]};
            // A column that lands this cycle is a miss only, never a hit.
            cand_s[i]  = bus.key_valid & enable_r[i] & ~miss_s[i] &
                         (bus.col_letter[8*i +: 8] == bus.key_code);
            // Strict '>' keeps the earlier (lower-index) column on equal ypos.
            if (cand_s[i] && (!win_found_s || (bus.col_ypos[5*i +: 5] > best_y_s))) begin
                win_found_s = 1'b1;
                best_y_s    = bus.col_ypos[5*i +: 5];
                win_s       = '0;
                win_s[i]    = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the game state machine.
    always_comb begin
        state_s     = state_r;
        score_s     = score_r;
        lives_s     = lives_r;
        period_s    = period_r;
        tick_cnt_s  = tick_cnt_r;
        hit_cnt_s   = hit_cnt_r;
        enable_s    = enable_r;
        col_tick_s  = '0;
        col_clear_s = '0;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_s     = ST_PLAYING;
                    score_s     = 10'd0;
                    lives_s     = LIVES_INIT;
                    period_s    = PERIOD_START;
                    tick_cnt_s  = 26'd0;
                    hit_cnt_s   = '0;
                    enable_s    = '0;
                    col_clear_s = '1;
                end else begin
                    state_s = state_r;
                end
            end

            ST_PLAYING: begin
                // '>=' rather than '==' so a period that shrank under the count still fires.
                if (tick_cnt_r >= (period_r - 26'd1)) begin
                    tick_cnt_s = 26'd0;
                    col_tick_s = enable_r;
                    // x | (x+1) sets the lowest clear bit: staggered column release.
                    enable_s   = enable_r | (enable_r + COL_ONE);
                end else begin
                    tick_cnt_s = tick_cnt_r + 26'd1;
                end

                col_clear_s = miss_s | win_s;

                if (win_found_s) begin
                    score_s = (score_r == 10'd1023) ? score_r : (score_r + 10'd1);
                    if (hit_cnt_r == HIT_LAST) begin
                        hit_cnt_s = '0;
                        period_s  = (period_r >= PERIOD_KNEE) ? (period_r - PERIOD_STEP)
                                                              : PERIOD_MIN;
                    end else begin
                        hit_cnt_s = hit_cnt_r + {{(HIT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    score_s = score_r;
                end

                // Losing the last life ends the game on this edge; any hit above still scores.
                if (miss_cnt_s != 4'd0) begin
                    if ({2'b00, lives_r} <= miss_cnt_s) begin
                        lives_s    = 2'd0;
                        state_s    = ST_OVER;
                        enable_s   = '0;
                        col_tick_s = '0;
                    end else begin
                        lives_s = lives_r - miss_cnt_s[1:0];
                    end
                end else begin
                    lives_s = lives_r;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                enable_s = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state_r     <= ST_IDLE;
            score_r     <= 10'd0;
            lives_r     <= LIVES_INIT;
            period_r    <= PERIOD_START;
            tick_cnt_r  <= 26'd0;
            hit_cnt_r   <= '0;
            enable_r    <= '0;
            col_tick_r  <= '0;
            col_clear_r <= '0;
            landed_q_r  <= '0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            score_r     <= score_s;
            lives_r     <= lives_s;
            period_r    <= period_s;
            tick_cnt_r  <= tick_cnt_s;
            hit_cnt_r   <= hit_cnt_s;
            enable_r    <= enable_s;
            col_tick_r  <= col_tick_s;
            col_clear_r <= col_clear_s;
            landed_q_r  <= bus.col_landed;
            game_over_r <= (state_s == ST_OVER);
        end
    end

    assign bus.col_enable = enable_r;
    assign bus.col_tick   = col_tick_r;
    assign bus.col_clear  = col_clear_r;
    assign bus.score      = score_r;
    assign bus.lives      = lives_r;
    assign bus.state      = state_r;
    assign bus.game_over  = game_over_r;

endmodule

// File: tb/tb_column_sequencer.sv
// tb_column_sequencer
//   Drives directed game scenarios followed by randomized play. A game-level
//   reference model predicts the score/lives/state/released columns and pushes
//   every expected tick/clear pulse into a queue; a monitor pops and compares
//   whenever the sequencer shows a pulse and checks status every cycle.
module tb_column_sequencer;
    localparam int N     = 4;
    localparam int TS    = 10;
    localparam int TMIN  = 4;
    localparam int TSTEP = 3;
    localparam int SE    = 2;
    localparam int ML    = 3;

    logic clock = 1'b0;
    logic reset_signal = 1'b1;
    always #5 clock = ~clock;

    column_sequencer_if #(.NUM_COLS(N)) bus ();

    column_sequencer #(
        .NUM_COLS(N), .TICK_START(TS), .TICK_MIN(TMIN), .TICK_STEP(TSTEP),
        .SPEEDUP_EVERY(SE), .MAX_LIVES(ML)
    ) dut (
        .clock(clock),
        .reset_signal(reset_signal),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // stimulus state
    int         let_a [N];
    int         y_a   [N];
    logic [N-1:0] land_v = '0;
    bit         kv = 1'b0;
    int         kc = 0;
    bit         st = 1'b0;

    // reference model state (game level)
    int m_state = 0, m_score = 0, m_lives = ML, m_period = TS;
    int m_since = 0, m_released = 0, m_hits = 0, cyc = 0;
    logic [N-1:0] m_prev = '0;

    typedef struct {
        int           cyc;
        logic [N-1:0] tick;
        logic [N-1:0] clear;
    } ev_t;
    ev_t evq[$];

    int last_tick = 0, tick_gap = 0, dut_ticks = 0;

    function automatic logic [N-1:0] en_of(input int r);
        logic [N-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) if (i < r) e[i] = 1'b1;
        return e;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.col_letter[8*i +: 8] = 8'(let_a[i]);
            bus.col_ypos[5*i +: 5]   = 5'(y_a[i]);
        end
        bus.col_landed = land_v;
        bus.key_valid  = kv;
        bus.key_code   = 8'(kc);
        bus.start      = st;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = ML; m_period = TS;
        m_since = 0; m_released = 0; m_hits = 0; m_prev = '0;
        evq.delete();
    endtask

    task automatic model_step();
        logic [N-1:0] en, miss, clr, tk;
        int nmiss, win, besty;
        ev_t e;
        en  = en_of(m_released);
        tk  = '0;
        clr = '0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_score = 0; m_lives = ML; m_period = TS;
                m_hits = 0; m_since = 0; m_released = 0;
                clr = '1;
            end
        end else begin
            miss  = land_v & ~m_prev & en;
            nmiss = $countones(miss);
            win   = -1;
            besty = -1;
            if (kv) begin
                for (int i = 0; i < N; i++)
                    if (en[i] && !miss[i] && let_a[i] == kc && y_a[i] > besty) begin
                        win = i;
                        besty = y_a[i];
                    end
            end
            clr = miss;
            m_since++;
            if (m_since >= m_period) begin
                tk = en;
                m_since = 0;
                if (m_released < N) m_released++;
            end
            if (win >= 0) begin
                clr[win] = 1'b1;
                m_score = (m_score < 1023) ? m_score + 1 : 1023;
                m_hits++;
                if (m_hits == SE) begin
                    m_hits = 0;
                    m_period = (m_period - TSTEP > TMIN) ? m_period - TSTEP : TMIN;
                end
            end
            if (nmiss > 0) begin
                m_lives = m_lives - nmiss;
                if (m_lives <= 0) begin
                    m_lives = 0;
                    m_state = 2;
                    m_released = 0;
                    tk = '0;
                end
            end
        end
        m_prev = land_v;
        if (tk != '0 || clr != '0) begin
            e.cyc = cyc; e.tick = tk; e.clear = clr;
            evq.push_back(e);
        end
    endtask

    // reference model process
    initial begin
        forever begin
            @(posedge clock or posedge reset_signal);
            if (reset_signal) begin
                model_reset();
            end else begin
                cyc++;
                model_step();
            end
        end
    end

    // monitor / scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            tests++;
            if (bus.score !== 10'(m_score) || bus.lives !== 2'(m_lives) ||
                bus.state !== 2'(m_state) || bus.game_over !== (m_state == 2) ||
                bus.col_enable !== en_of(m_released)) begin
                fails++;
                $display("FAIL status cyc=%0d actual score/lives/state/go/en=%0d/%0d/%0d/%0d/%b expected=%0d/%0d/%0d/%0d/%b",
                         cyc, bus.score, bus.lives, bus.state, bus.game_over, bus.col_enable,
                         m_score, m_lives, m_state, (m_state == 2), en_of(m_released));
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_pulse cyc=%0d actual=none expected tick=%b clear=%b",
                         evq[0].cyc, evq[0].tick, evq[0].clear);
                void'(evq.pop_front());
            end
            if (bus.col_tick != '0 || bus.col_clear != '0) begin
                tests++;
                if (evq.size() == 0 || evq[0].cyc != cyc) begin
                    fails++;
                    $display("FAIL spurious_pulse cyc=%0d actual tick=%b clear=%b expected none",
                             cyc, bus.col_tick, bus.col_clear);
                end else begin
                    e = evq.pop_front();
                    if (bus.col_tick !== e.tick || bus.col_clear !== e.clear) begin
                        fails++;
                        $display("FAIL pulse cyc=%0d actual tick=%b clear=%b expected tick=%b clear=%b",
                                 cyc, bus.col_tick, bus.col_clear, e.tick, e.clear);
                    end
                end
                if (bus.col_tick != '0) begin
                    tick_gap  = cyc - last_tick;
                    last_tick = cyc;
                    dut_ticks++;
                end
            end
        end
    end

    task automatic key(input int code);
        kv = 1'b1; kc = code; apply();
        @(negedge clock);
        kv = 1'b0; apply();
    endtask

    task automatic pulse_start();
        st = 1'b1; apply();
        @(negedge clock);
        st = 1'b0; apply();
    endtask

    initial begin
        int snap;
        let_a = '{65, 65, 67, 68};
        y_a   = '{5, 9, 0, 0};
        apply();
        repeat (3) @(negedge clock);
        reset_signal = 1'b0;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_lives", int'(bus.lives), 3);
        chk("reset_pulses", int'({bus.col_enable, bus.col_tick, bus.col_clear}), 0);

        // 1: start, staggered release, 10-cycle ticks
        pulse_start();
        chk("start_clear", int'(bus.col_clear), 15);
        repeat (45) @(negedge clock);
        chk("enable_ramp", int'(bus.col_enable), 15);
        chk("gap_10", tick_gap, 10);

        // 2: deeper of two matching columns wins
        key(65);
        chk("hit_deeper", int'(bus.col_clear), 2);
        chk("score_1", int'(bus.score), 1);

        // 3: tie goes to lowest index
        let_a = '{65, 66, 67, 66};
        y_a   = '{5, 7, 0, 7};
        apply();
        key(66);
        chk("hit_tie", int'(bus.col_clear), 2);

        // 4: land and match same cycle -> miss only
        land_v = 4'b0100; kv = 1'b1; kc = 67; apply();
        @(negedge clock);
        land_v = '0; kv = 1'b0; apply();
        chk("miss_clear", int'(bus.col_clear), 4);
        chk("miss_lives", int'(bus.lives), 2);
        chk("miss_score", int'(bus.score), 2);

        // 5: speed-up to 7, then floor at 4
        repeat (30) @(negedge clock);
        chk("gap_7", tick_gap, 7);
        let_a = '{65, 65, 67, 68};
        y_a   = '{5, 9, 0, 0};
        apply();
        for (int h = 0; h < 4; h++) begin
            key(65);
            @(negedge clock);
        end
        repeat (20) @(negedge clock);
        chk("gap_4", tick_gap, 4);
        chk("score_6", int'(bus.score), 6);

        // 6: two more misses end the game
        land_v = 4'b0001; apply(); @(negedge clock);
        land_v = '0;      apply(); @(negedge clock);
        land_v = 4'b0010; apply(); @(negedge clock);
        land_v = '0;      apply();
        chk("over_state", int'(bus.state), 2);
        chk("over_flag", int'(bus.game_over), 1);
        chk("over_enable", int'(bus.col_enable), 0);
        snap = dut_ticks;
        repeat (20) @(negedge clock);
        chk("over_no_ticks", dut_ticks - snap, 0);
        chk("over_score_hold", int'(bus.score), 6);

        pulse_start();
        chk("restart_state", int'(bus.state), 1);
        repeat (14) @(negedge clock);
        key(65);
        chk("restart_hit", int'(bus.score), 1);
        #2 reset_signal = 1'b1;
        #1;
        chk("async_reset_state", int'(bus.state), 0);
        chk("async_reset_score", int'(bus.score), 0);
        @(negedge clock);
        reset_signal = 1'b0;
        pulse_start();
        chk("new_game_lives", int'(bus.lives), 3);
        chk("new_game_score", int'(bus.score), 0);

        // randomized play
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) let_a[i] = 65 + int'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) y_a[i] = int'($urandom_range(0, 31));
                if ($urandom_range(0, 47) == 0) land_v[i] = ~land_v[i];
            end
            kv = ($urandom_range(0, 2) == 0);
            kc = 65 + int'($urandom_range(0, 3));
            st = (m_state != 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            apply();
            if ($urandom_range(0, 1499) == 0) begin
                #2 reset_signal = 1'b1;
                @(negedge clock);
                reset_signal = 1'b0;
            end else begin
                @(negedge clock);
            end
        end
        st = 1'b0; kv = 1'b0; apply();
        repeat (3) @(negedge clock);
        chk("queue_drained", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
